tour_cmd_sequencer: RTL and testbench

Command-source arbiter and sequencer between the UART command path and the command processor. In idle it passes host commands straight through. On a tour start it takes over the command port, decomposes each of the 24 knight moves from the tour-solver into a vertical leg and a horizontal leg, and sends them in order. It also supplies the response byte sent back to the host.

---
 rtl/tour_pkg.sv | 32 +++
 rtl/tour_cmd_sequencer_if.sv | 29 ++
 rtl/knight_move_decode.sv | 56 +++++
 rtl/tour_cmd_sequencer.sv | 99 +++++++++
 tb/tb_tour_cmd_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/tour_pkg.sv
// Shared constants for the knight-tour command sequencer.
// Opcodes, headings, response codes and FSM state encodings.
package tour_pkg;

    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_FANFARE = 4'h5;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_MOVE_Y = 3'd1;
    localparam state_t S_WAIT_Y = 3'd2;
    localparam state_t S_MOVE_X = 3'd3;
    localparam state_t S_WAIT_X = 3'd4;

    function automatic logic [15:0] leg_cmd(
        input logic [3:0] op,
        input logic [7:0] hdg,
        input logic [3:0] sq
    );
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/tour_cmd_sequencer_if.sv
// Command-path bundle between host/UART, tour solver and command processor.
// master = environment side, slave = sequencer side.
interface tour_cmd_sequencer_if;

    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        output cmd_UART, cmd_rdy_UART, start_tour, move,
        output clr_cmd_rdy, send_resp,
        input  clr_cmd_rdy_UART, mv_indx, cmd, cmd_rdy, resp
    );

    modport slave (
        input  cmd_UART, cmd_rdy_UART, start_tour, move,
        input  clr_cmd_rdy, send_resp,
        output clr_cmd_rdy_UART, mv_indx, cmd, cmd_rdy, resp
    );

endinterface

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into a vertical and a horizontal leg command.
// Anything other than exactly one set bit is flagged illegal.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] y_cmd,
    output logic [15:0] x_cmd,
    output logic        illegal
);

    always_comb begin
        y_cmd   = '0;
        x_cmd   = '0;
        illegal = !$onehot(move);
        // Guarded so the unique decode only ever sees a single hot bit
        if (!illegal) begin
            unique case (1'b1)
                move[0]: begin
                    y_cmd = leg_cmd(OP_MOVE, HDG_N, 4'd2);
                    x_cmd = leg_cmd(OP_FANFARE, HDG_E, 4'd1);
                end
                move[1]: begin
                    y_cmd = leg_cmd(OP_MOVE, HDG_N, 4'd2);
                    x_cmd = leg_cmd(OP_FANFARE, HDG_W, 4'd1);
                end
                move[2]: begin
                    y_cmd = leg_cmd(OP_MOVE, HDG_N, 4'd1);
                    x_cmd = leg_cmd(OP_FANFARE, HDG_W, 4'd2);
                end
                move[3]: begin
                    y_cmd = leg_cmd(OP_MOVE, HDG_S, 4'd1);
                    x_cmd = leg_cmd(OP_FANFARE, HDG_W, 4'd2);
                end
                move[4]: begin
                    y_cmd = leg_cmd(OP_MOVE, HDG_S, 4'd2);
                    x_cmd = leg_cmd(OP_FANFARE, HDG_W, 4'd1);
                end
                move[5]: begin
                    y_cmd = leg_cmd(OP_MOVE, HDG_S, 4'd2);
                    x_cmd = leg_cmd(OP_FANFARE, HDG_E, 4'd1);
                end
                move[6]: begin
                    y_cmd = leg_cmd(OP_MOVE, HDG_S, 4'd1);
                    x_cmd = leg_cmd(OP_FANFARE, HDG_E, 4'd2);
                end
                move[7]: begin
                    y_cmd = leg_cmd(OP_MOVE, HDG_N, 4'd1);
                    x_cmd = leg_cmd(OP_FANFARE, HDG_E, 4'd2);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Arbitrates the command port between the UART host and the knight tour,
// issuing each tour move as a Y leg followed by an X leg.
module tour_cmd_sequencer
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input logic                 clk,
    input logic                 rst_n,
    tour_cmd_sequencer_if.slave bus
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  idx;
    logic [15:0] y_cmd;
    logic [15:0] x_cmd;
    logic        illegal;
    logic        last;
    logic [15:0] cmd_o;
    logic        cmd_rdy_o;
    logic        clr_uart_o;
    logic [7:0]  resp_o;

    knight_move_decode u_dec (
        .move    (bus.move),
        .y_cmd   (y_cmd),
        .x_cmd   (x_cmd),
        .illegal (illegal)
    );

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.start_tour)
                idx <= '0;
            else if (state == S_WAIT_X && bus.send_resp && !last)
                idx <= idx + 5'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_o      = bus.cmd_UART;
        cmd_rdy_o  = 1'b0;
        clr_uart_o = 1'b0;
        resp_o     = RESP_BUSY;
        case (state)
            S_IDLE: begin
                cmd_rdy_o  = bus.cmd_rdy_UART;
                clr_uart_o = bus.clr_cmd_rdy;
                resp_o     = RESP_DONE;
                if (bus.start_tour)
                    state_nxt = S_MOVE_Y;
            end
            S_MOVE_Y: begin
                cmd_o     = y_cmd;
                cmd_rdy_o = !illegal;
                if (illegal)
                    state_nxt = S_IDLE;
                else if (bus.clr_cmd_rdy)
                    state_nxt = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                cmd_o = y_cmd;
                if (bus.send_resp)
                    state_nxt = S_MOVE_X;
            end
            S_MOVE_X: begin
                cmd_o     = x_cmd;
                cmd_rdy_o = 1'b1;
                if (bus.clr_cmd_rdy)
                    state_nxt = S_WAIT_X;
            end
            S_WAIT_X: begin
                cmd_o = x_cmd;
                if (last)
                    resp_o = RESP_DONE;
                if (bus.send_resp)
                    state_nxt = last ? S_IDLE : S_MOVE_Y;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.cmd              = cmd_o;
    assign bus.cmd_rdy          = cmd_rdy_o;
    assign bus.clr_cmd_rdy_UART = clr_uart_o;
    assign bus.resp             = resp_o;
    assign bus.mv_indx          = idx;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer: passthrough, leg decode, full tour,
// illegal-move abort and mid-tour reset.
module tb_tour_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_cmds = 0;

    tour_cmd_sequencer_if bus ();

    tour_cmd_sequencer #(.NUM_MOVES(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Hand-decoded leg commands indexed by the hot move bit
    logic [15:0] exp_y [8] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1,
                               16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
    logic [15:0] exp_x [8] = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2,
                               16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2};
    int bit_seq [8] = '{0, 3, 5, 1, 2, 4, 6, 7};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] m);
        bus.move       = m;
        bus.start_tour = 1'b1;
        step();
        bus.start_tour = 1'b0;
    endtask

    // One leg: expect cmd_rdy now, handshake, then answer in the wait state
    task automatic leg(input string tag, input logic [15:0] exp_cmd,
                       input int idx, input bit both,
                       input logic [7:0] wait_resp);
        #1;
        chk($sformatf("%s_rdy", tag), 32'(bus.cmd_rdy), 32'd1);
        chk($sformatf("%s_cmd", tag), 32'(bus.cmd), 32'(exp_cmd));
        chk($sformatf("%s_idx", tag), 32'(bus.mv_indx), 32'(idx));
        chk($sformatf("%s_resp", tag), 32'(bus.resp), 32'h5A);
        chk($sformatf("%s_uclr", tag), 32'(bus.clr_cmd_rdy_UART), 32'd0);
        if (bus.cmd_rdy) n_cmds++;
        bus.clr_cmd_rdy = 1'b1;
        bus.send_resp   = both;
        step();
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        chk($sformatf("%s_drop", tag), 32'(bus.cmd_rdy), 32'd0);
        if (both) begin
            step();
            chk($sformatf("%s_hold", tag), 32'(bus.cmd_rdy), 32'd0);
            chk($sformatf("%s_hcmd", tag), 32'(bus.cmd), 32'(exp_cmd));
        end
        chk($sformatf("%s_wresp", tag), 32'(bus.resp), 32'(wait_resp));
        bus.send_resp = 1'b1;
        step();
        bus.send_resp = 1'b0;
    endtask

    task automatic run_moves(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            int b;
            b = bit_seq[i % 8];
            bus.move = 8'h01 << b;
            if (i == 0) start(bus.move);
            if (full && i == 3) begin
                bus.start_tour = 1'b1;
                step();
                bus.start_tour = 1'b0;
                chk("mid_start_idx", 32'(bus.mv_indx), 32'd3);
                chk("mid_start_rdy", 32'(bus.cmd_rdy), 32'd1);
                chk("mid_start_cmd", 32'(bus.cmd), 32'(exp_y[b]));
            end
            leg($sformatf("y%0d", i), exp_y[b], i, full && i == 7, 8'h5A);
            leg($sformatf("x%0d", i), exp_x[b], i, 1'b0,
                (full && i == 23) ? 8'hA5 : 8'h5A);
        end
    endtask

    initial begin
        bus.cmd_UART     = 16'h0000;
        bus.cmd_rdy_UART = 1'b0;
        bus.start_tour   = 1'b0;
        bus.move         = 8'h00;
        bus.clr_cmd_rdy  = 1'b0;
        bus.send_resp    = 1'b0;
        #12;
        chk("rst_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("rst_idx", 32'(bus.mv_indx), 32'd0);
        chk("rst_resp", 32'(bus.resp), 32'hA5);
        rst_n = 1'b1;
        step();

        bus.cmd_UART     = 16'h2000;
        bus.cmd_rdy_UART = 1'b1;
        bus.clr_cmd_rdy  = 1'b1;
        #1;
        chk("pt_cmd", 32'(bus.cmd), 32'h2000);
        chk("pt_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("pt_clr", 32'(bus.clr_cmd_rdy_UART), 32'd1);
        chk("pt_resp", 32'(bus.resp), 32'hA5);
        bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy  = 1'b0;
        step();

        run_moves(24, 1'b1);
        chk("tour_ncmds", 32'(n_cmds), 32'd48);
        chk("end_idx", 32'(bus.mv_indx), 32'd23);
        chk("end_resp", 32'(bus.resp), 32'hA5);
        bus.cmd_UART     = 16'h1234;
        bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("end_pt_cmd", 32'(bus.cmd), 32'h1234);
        chk("end_pt_rdy", 32'(bus.cmd_rdy), 32'd1);
        bus.cmd_rdy_UART = 1'b0;
        step();

        run_moves(5, 1'b0);
        bus.move         = 8'h03;
        bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("ill_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("ill_idx", 32'(bus.mv_indx), 32'd5);
        step();
        chk("ill_idle_resp", 32'(bus.resp), 32'hA5);
        chk("ill_idle_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("ill_idle_cmd", 32'(bus.cmd), 32'h1234);
        bus.cmd_rdy_UART = 1'b0;
        step();

        run_moves(10, 1'b0);
        bus.move = 8'h08;
        leg("y10", 16'h47F1, 10, 1'b0, 8'h5A);
        #1;
        chk("x10_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("x10_cmd", 32'(bus.cmd), 32'h53F2);
        rst_n = 1'b0;
        #1;
        chk("mrst_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("mrst_idx", 32'(bus.mv_indx), 32'd0);
        chk("mrst_resp", 32'(bus.resp), 32'hA5);
        step();
        rst_n = 1'b1;
        step();
        start(8'h01);
        #1;
        chk("rs_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("rs_idx", 32'(bus.mv_indx), 32'd0);
        chk("rs_cmd", 32'(bus.cmd), 32'h4002);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
